// File: rtl/lcd_spi_sequencer.sv
// Drains {delay, dc, byte} words from a FIFO read port and sends them on a mode-0, MSB-first 4-wire SPI LCD bus.
// Delay words hold the sequencer for count*DELAY_TICKS cycles so init waits can be queued with the commands.
module lcd_spi_sequencer #(
  parameter int CLK_DIV     = 2,
  parameter int DELAY_TICKS = 27000,
  parameter int WORD_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [WORD_WIDTH-1:0] rd_data,
  output logic                  lcd_sck,
  output logic                  lcd_mosi,
  output logic                  lcd_cs_n,
  output logic                  lcd_dc,
  output logic                  busy
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int TICK_W = $clog2(DELAY_TICKS + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DELAY_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DELAY} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DIV_W-1:0]    div_cnt;
  logic [3:0]          half_cnt;
  logic [6:0]          shreg;
  logic [7:0]          unit_cnt;
  logic [TICK_W-1:0]   tick_cnt;

  logic pop;
  logic div_end;
  logic tick_end;
  logic shift_done;
  logic delay_done;

  assign pop        = rd_ready && rd_valid;
  assign div_end    = (div_cnt == DIV_LAST);
  assign tick_end   = (tick_cnt == TICK_LAST);
  assign shift_done = div_end && (half_cnt == 4'd15);
  // A zero count leaves DELAY after its single entry cycle.
  assign delay_done = (unit_cnt == 8'd0) || ((unit_cnt == 8'd1) && tick_end);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop) begin
          state_nxt = rd_data[9] ? DELAY : SHIFT;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_nxt = GAP;
        end
      end
      GAP: begin
        if (div_end) begin
          state_nxt = IDLE;
        end
      end
      DELAY: begin
        if (delay_done) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_ready = (state == IDLE) && enable;
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      unit_cnt <= '0;
      tick_cnt <= '0;
      lcd_sck  <= 1'b0;
      lcd_mosi <= 1'b0;
      lcd_cs_n <= 1'b1;
      lcd_dc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if (rd_data[9]) begin
              unit_cnt <= rd_data[7:0];
              tick_cnt <= '0;
            end else begin
              shreg    <= rd_data[6:0];
              lcd_mosi <= rd_data[7];
              lcd_dc   <= rd_data[8];
              lcd_cs_n <= 1'b0;
              lcd_sck  <= 1'b0;
              div_cnt  <= '0;
              half_cnt <= '0;
            end
          end
        end
        SHIFT: begin
          if (div_end) begin
            div_cnt  <= '0;
            half_cnt <= half_cnt + 4'd1;
            // Even half-periods end in a rising edge, odd ones in a falling edge.
            if (!half_cnt[0]) begin
              lcd_sck <= 1'b1;
            end else begin
              lcd_sck <= 1'b0;
              if (half_cnt == 4'd15) begin
                lcd_cs_n <= 1'b1;
                lcd_mosi <= 1'b0;
              end else begin
                lcd_mosi <= shreg[6];
                shreg    <= {shreg[5:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          div_cnt <= div_end ? '0 : div_cnt + DIV_W'(1);
        end
        DELAY: begin
          if (unit_cnt != 8'd0) begin
            if (tick_end) begin
              tick_cnt <= '0;
              unit_cnt <= unit_cnt - 8'd1;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        default: begin
          lcd_sck  <= 1'b0;
          lcd_cs_n <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_sequencer.sv
// Bench for lcd_spi_sequencer: a queue-modelled FIFO feeds words, an SPI decoder
// checks each frame against the word popped for it.
module tb_lcd_spi_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       rd_valid = 1'b0;
  logic       rd_ready;
  logic [9:0] rd_data = 10'h000;
  logic       lcd_sck, lcd_mosi, lcd_cs_n, lcd_dc, busy;

  lcd_spi_sequencer #(.CLK_DIV(2), .DELAY_TICKS(10), .WORD_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .lcd_sck(lcd_sck), .lcd_mosi(lcd_mosi), .lcd_cs_n(lcd_cs_n),
    .lcd_dc(lcd_dc), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [9:0] fifo_q[$];
  logic [8:0] exp_q[$];
  int         pop_cycs[$];
  int         busy_lens[$];
  int         busy_falls[$];

  int         cyc = 0;
  logic       pop_pending = 1'b0;
  logic       in_frame = 1'b0;
  logic       prev_sck = 1'b0;
  logic [7:0] bits = 8'h00;
  logic       frame_dc = 1'b0;
  int         low_cnt = 0;
  int         rise_cnt = 0;
  int         frames = 0;
  int         last_low = 0;
  int         last_rises = 0;
  int         gap_busy_run = 0;
  int         last_gap_busy = 0;
  int         cs_low_total = 0;
  int         sck_bad = 0;
  logic       busy_hi = 1'b0;
  int         busy_rise = 0;

  // Pop decision taken from stable pre-edge values, well before the rising edge.
  always @(negedge clk) begin
    #3;
    pop_pending = rst && rd_ready && rd_valid;
  end

  always @(posedge clk) begin
    logic [9:0] w;
    #1;
    cyc++;
    if (!rst) begin
      in_frame     = 1'b0;
      rise_cnt     = 0;
      gap_busy_run = 0;
      busy_hi      = 1'b0;
      exp_q.delete();
    end else begin
      if (pop_pending) begin
        w = fifo_q.pop_front();
        pop_cycs.push_back(cyc);
        if (!w[9]) exp_q.push_back(w[8:0]);
      end
      if (!in_frame && !lcd_cs_n) begin
        in_frame      = 1'b1;
        low_cnt       = 0;
        rise_cnt      = 0;
        bits          = 8'h00;
        frame_dc      = lcd_dc;
        last_gap_busy = gap_busy_run;
      end
      if (in_frame && lcd_cs_n) begin
        in_frame     = 1'b0;
        gap_busy_run = 0;
        frames++;
        last_low   = low_cnt;
        last_rises = rise_cnt;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected got dc=%0b byte=%h required no frame", frame_dc, bits);
        end else begin
          w[8:0] = exp_q.pop_front();
          if ({frame_dc, bits} !== w[8:0]) begin
            errors++;
            $display("FAIL frame_content got dc=%0b byte=%h required dc=%0b byte=%h",
                     frame_dc, bits, w[8], w[7:0]);
          end
        end
      end
      if (in_frame) begin
        low_cnt++;
        cs_low_total++;
        if (lcd_sck && !prev_sck) begin
          bits = {bits[6:0], lcd_mosi};
          rise_cnt++;
        end
      end
      if (lcd_cs_n && busy) gap_busy_run++;
      if (lcd_sck && lcd_cs_n) sck_bad++;
      if (busy && !busy_hi) begin
        busy_hi   = 1'b1;
        busy_rise = cyc;
      end else if (!busy && busy_hi) begin
        busy_hi = 1'b0;
        busy_lens.push_back(cyc - busy_rise);
        busy_falls.push_back(cyc);
      end
    end
    prev_sck = lcd_sck;
    rd_valid = (fifo_q.size() != 0);
    rd_data  = (fifo_q.size() != 0) ? fifo_q[0] : 10'h000;
  end

  task automatic wait_drain(input int budget, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(fifo_q.size() == 0 && !rd_valid && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got still busy after %0d cycles required drained", tag, budget);
    end
  endtask

  task automatic clear_logs();
    pop_cycs.delete();
    busy_lens.delete();
    busy_falls.delete();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lcd_sck, lcd_mosi, lcd_cs_n, lcd_dc} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_pins got sck,mosi,cs_n,dc=%b required 0010", {lcd_sck, lcd_mosi, lcd_cs_n, lcd_dc});
    end
    checks++;
    if ({rd_ready, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_ctrl got rd_ready,busy=%b required 00", {rd_ready, busy});
    end
    rst = 1'b1;
    enable = 1'b1;
    #1;
    checks++;
    if (rd_ready !== 1'b1) begin
      errors++;
      $display("FAIL rd_ready_enable got %b required 1", rd_ready);
    end
    repeat (6) @(negedge clk);
    checks++;
    if ({lcd_sck, lcd_cs_n, busy} !== 3'b010 || pop_cycs.size() != 0) begin
      errors++;
      $display("FAIL empty_idle got sck,cs_n,busy=%b pops=%0d required 010 pops=0",
               {lcd_sck, lcd_cs_n, busy}, pop_cycs.size());
    end
  endtask

  task automatic test_single_byte();
    int f0;
    clear_logs();
    f0 = frames;
    @(negedge clk);
    fifo_q.push_back(10'h02A);
    wait_drain(200, "single");
    checks++;
    if (frames != f0 + 1) begin
      errors++;
      $display("FAIL single_frames got %0d required %0d", frames - f0, 1);
    end
    checks++;
    if (last_low != 32) begin
      errors++;
      $display("FAIL single_cs_low got %0d required 32", last_low);
    end
    checks++;
    if (last_rises != 8) begin
      errors++;
      $display("FAIL single_rises got %0d required 8", last_rises);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    clear_logs();
    f0 = frames;
    @(negedge clk);
    fifo_q.push_back(10'h136);
    fifo_q.push_back(10'h1FF);
    wait_drain(300, "b2b");
    checks++;
    if (frames != f0 + 2) begin
      errors++;
      $display("FAIL b2b_frames got %0d required 2", frames - f0);
    end
    checks++;
    if (pop_cycs.size() != 2 || pop_cycs[1] - pop_cycs[0] != 35) begin
      errors++;
      $display("FAIL b2b_pop_spacing got pops=%0d spacing=%0d required 2 pops 35 apart",
               pop_cycs.size(), (pop_cycs.size() == 2) ? pop_cycs[1] - pop_cycs[0] : -1);
    end
    // cs_n-high cycles spent in GAP between the two frames.
    checks++;
    if (last_gap_busy != 2) begin
      errors++;
      $display("FAIL b2b_gap got %0d required 2", last_gap_busy);
    end
    checks++;
    if (last_low != 32) begin
      errors++;
      $display("FAIL b2b_cs_low got %0d required 32", last_low);
    end
  endtask

  task automatic test_delay();
    int f0;
    int l0;
    clear_logs();
    f0 = frames;
    l0 = cs_low_total;
    @(negedge clk);
    fifo_q.push_back(10'h203);
    fifo_q.push_back(10'h055);
    wait_drain(300, "delay");
    checks++;
    if (busy_lens.size() < 1 || busy_lens[0] != 30) begin
      errors++;
      $display("FAIL delay_busy got %0d required 30", (busy_lens.size() > 0) ? busy_lens[0] : -1);
    end
    checks++;
    if (pop_cycs.size() != 2 || busy_falls.size() < 1 || pop_cycs[1] != busy_falls[0] + 1) begin
      errors++;
      $display("FAIL delay_next_pop got pops=%0d offset=%0d required next pop 1 cycle after busy falls",
               pop_cycs.size(),
               (pop_cycs.size() == 2 && busy_falls.size() > 0) ? pop_cycs[1] - busy_falls[0] : -1);
    end
    checks++;
    if (frames != f0 + 1 || cs_low_total != l0 + 32) begin
      errors++;
      $display("FAIL delay_bus_quiet got frames=%0d cs_low=%0d required frames=1 cs_low=32",
               frames - f0, cs_low_total - l0);
    end
  endtask

  task automatic test_zero_delay();
    int f0;
    int l0;
    clear_logs();
    f0 = frames;
    l0 = cs_low_total;
    @(negedge clk);
    fifo_q.push_back(10'h200);
    wait_drain(100, "zero_delay");
    checks++;
    if (busy_lens.size() != 1 || busy_lens[0] != 1) begin
      errors++;
      $display("FAIL zero_delay_busy got n=%0d len=%0d required one 1-cycle busy",
               busy_lens.size(), (busy_lens.size() > 0) ? busy_lens[0] : -1);
    end
    checks++;
    if (frames != f0 || cs_low_total != l0) begin
      errors++;
      $display("FAIL zero_delay_bus got frames=%0d cs_low=%0d required 0 0", frames - f0, cs_low_total - l0);
    end
  endtask

  task automatic test_enable_pause();
    int f0;
    int n;
    int en_cyc;
    clear_logs();
    f0 = frames;
    @(negedge clk);
    fifo_q.push_back(10'h0C3);
    fifo_q.push_back(10'h15A);
    fifo_q.push_back(10'h0F0);
    fifo_q.push_back(10'h181);
    n = 0;
    while (pop_cycs.size() == 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    enable = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if (pop_cycs.size() != 1) begin
      errors++;
      $display("FAIL pause_pops got %0d required 1", pop_cycs.size());
    end
    checks++;
    if (frames != f0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pause_byte_done got frames=%0d busy=%b required 1 0", frames - f0, busy);
    end
    en_cyc = cyc + 1;
    enable = 1'b1;
    wait_drain(400, "pause");
    checks++;
    if (pop_cycs.size() < 2 || pop_cycs[1] != en_cyc) begin
      errors++;
      $display("FAIL pause_resume got pop at %0d required %0d",
               (pop_cycs.size() > 1) ? pop_cycs[1] : -1, en_cyc);
    end
    checks++;
    if (frames != f0 + 4) begin
      errors++;
      $display("FAIL pause_frames got %0d required 4", frames - f0);
    end
  endtask

  task automatic test_reset_mid_byte();
    int f0;
    int n;
    clear_logs();
    f0 = frames;
    @(negedge clk);
    fifo_q.push_back(10'h1A5);
    fifo_q.push_back(10'h03C);
    n = 0;
    while (!(in_frame && rise_cnt >= 3) && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({lcd_cs_n, lcd_sck, busy, lcd_mosi} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_pins got cs_n,sck,busy,mosi=%b required 1000",
               {lcd_cs_n, lcd_sck, busy, lcd_mosi});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_drain(200, "midreset");
    checks++;
    if (frames != f0 + 1) begin
      errors++;
      $display("FAIL midreset_frames got %0d required 1", frames - f0);
    end
    checks++;
    if (pop_cycs.size() != 2) begin
      errors++;
      $display("FAIL midreset_pops got %0d required 2", pop_cycs.size());
    end
    checks++;
    if (last_low != 32 || last_rises != 8) begin
      errors++;
      $display("FAIL midreset_clean got cs_low=%0d rises=%0d required 32 8", last_low, last_rises);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_delay();
    test_zero_delay();
    test_enable_pause();
    test_reset_mid_byte();
    checks++;
    if (sck_bad != 0) begin
      errors++;
      $display("FAIL sck_outside_cs got %0d cycles required 0", sck_bad);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_missing got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
